// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - multi-read-port integer register file with per-register busy scoreboard
//
// Purpose: ID-stage register file. NRD combinational read ports with optional
// same-cycle write-to-read bypass, plus a busy bit per register that is set when
// a producer issues (alloc), cleared at writeback and cleared in bulk on flush.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   rd_addr  [NRD*AW]     packed read addresses, port k = bits [k*AW +: AW]
//   rd_used  [NRD]        port k operand is consumed by the instruction
//   rd_data  [NRD*XLEN]   packed read data
//   rd_busy  [NRD]        port k operand has a pending producer
//   stall                 OR over k of rd_busy[k] & rd_used[k]
//   wr_en/wr_addr/wr_data writeback port
//   alloc_en/alloc_addr   issue marks destination pending
//   flush                 clear all busy bits
//   busy_vec [NREGS]      current busy bits
module reg_file_sb #(
   parameter int XLEN   = 32,
   parameter int NREGS  = 32,
   parameter int AW     = $clog2(NREGS),
   parameter int NRD    = 2,
   parameter bit BYPASS = 1'b1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NRD*AW-1:0]   rd_addr,
   input  logic [NRD-1:0]      rd_used,
   output logic [NRD*XLEN-1:0] rd_data,
   output logic [NRD-1:0]      rd_busy,
   output logic                stall,
   input  logic                wr_en,
   input  logic [AW-1:0]       wr_addr,
   input  logic [XLEN-1:0]     wr_data,
   input  logic                alloc_en,
   input  logic [AW-1:0]       alloc_addr,
   input  logic                flush,
   output logic [NREGS-1:0]    busy_vec
);

   // Storage spans the full address space so any AW-bit index is legal; entries
   // at 0 and >= NREGS are only ever reset, so they stay constant zero.
   localparam int DEPTH = 2 ** AW;
   localparam logic [AW:0] NREGS_W = NREGS[AW:0];

   logic [XLEN-1:0]  regs [DEPTH];
   logic [NREGS-1:0] busy;
   logic [NREGS-1:0] busy_next;
   logic [DEPTH-1:0] busy_ext;
   logic             wr_ok;
   logic             alloc_ok;

   function automatic logic addr_ok(input logic [AW-1:0] a);
      return (a != '0) && ({1'b0, a} < NREGS_W);
   endfunction

   assign wr_ok    = wr_en && addr_ok(wr_addr);
   assign alloc_ok = alloc_en && addr_ok(alloc_addr);
   assign busy_ext = DEPTH'(busy);
   assign busy_vec = busy;

   // Busy priority: alloc beats flush beats writeback, so a producer issued in
   // the same cycle as a flush or a writeback to its destination stays pending.
   always_comb begin
      busy_next = busy;
      busy_next[0] = 1'b0;
      for (int r = 1; r < NREGS; r++) begin
         if (alloc_ok && alloc_addr == AW'(r))
            busy_next[r] = 1'b1;
         else if (flush)
            busy_next[r] = 1'b0;
         else if (wr_ok && wr_addr == AW'(r))
            busy_next[r] = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int r = 0; r < DEPTH; r++)
            regs[r] <= '0;
         busy <= '0;
      end else begin
         if (wr_ok)
            regs[wr_addr] <= wr_data;
         busy <= busy_next;
      end
   end

   always_comb begin
      logic [AW-1:0] a;
      rd_data = '0;
      rd_busy = '0;
      for (int k = 0; k < NRD; k++) begin
         a = rd_addr[k*AW +: AW];
         if (addr_ok(a)) begin
            if (BYPASS && wr_ok && wr_addr == a) begin
               // Forwarded operand is ready unless a new producer claims it now.
               rd_data[k*XLEN +: XLEN] = wr_data;
               rd_busy[k]              = alloc_ok && (alloc_addr == a);
            end else begin
               rd_data[k*XLEN +: XLEN] = regs[a];
               rd_busy[k]              = busy_ext[a];
            end
         end
      end
   end

   assign stall = |(rd_busy & rd_used);

endmodule

// File: tb/tb_reg_file_sb.sv
// tb/tb_reg_file_sb.sv - randomized self-checking bench for reg_file_sb against a behavioural model
module tb_reg_file_sb;

   logic        clk = 1'b0;
   logic        reset;
   logic        wr_en, alloc_en, flush;
   logic [4:0]  wr_addr, alloc_addr;
   logic [31:0] wr_data;

   // Instance a: NREGS=32, NRD=2, bypass on
   logic [9:0]  rd_addr_a;
   logic [1:0]  rd_used_a;
   logic [63:0] rd_data_a;
   logic [1:0]  rd_busy_a;
   logic        stall_a;
   logic [31:0] busy_vec_a;

   // Instance b: NREGS=16 with 5-bit addresses (16..31 out of range), NRD=3, bypass off
   logic [14:0] rd_addr_b;
   logic [2:0]  rd_used_b;
   logic [95:0] rd_data_b;
   logic [2:0]  rd_busy_b;
   logic        stall_b;
   logic [15:0] busy_vec_b;

   int n_checks = 0;
   int n_pass   = 0;

   logic [31:0] m_regs [2][32];
   bit          m_busy [2][32];
   int          m_nregs [2] = '{32, 16};
   bit          m_byp   [2] = '{1'b1, 1'b0};

   always #5 clk = ~clk;

   reg_file_sb #(.XLEN(32), .NREGS(32), .AW(5), .NRD(2), .BYPASS(1'b1)) dut_a (
      .clk(clk), .reset(reset),
      .rd_addr(rd_addr_a), .rd_used(rd_used_a), .rd_data(rd_data_a),
      .rd_busy(rd_busy_a), .stall(stall_a),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .alloc_en(alloc_en), .alloc_addr(alloc_addr), .flush(flush),
      .busy_vec(busy_vec_a)
   );

   reg_file_sb #(.XLEN(32), .NREGS(16), .AW(5), .NRD(3), .BYPASS(1'b0)) dut_b (
      .clk(clk), .reset(reset),
      .rd_addr(rd_addr_b), .rd_used(rd_used_b), .rd_data(rd_data_b),
      .rd_busy(rd_busy_b), .stall(stall_b),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .alloc_en(alloc_en), .alloc_addr(alloc_addr), .flush(flush),
      .busy_vec(busy_vec_b)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
   endtask

   function automatic bit in_range(int m, logic [4:0] a);
      return (a != 0) && (int'(a) < m_nregs[m]);
   endfunction

   function automatic logic [31:0] exp_data(int m, logic [4:0] a);
      if (!in_range(m, a)) return 32'h0;
      if (m_byp[m] && wr_en && wr_addr == a) return wr_data;
      return m_regs[m][a];
   endfunction

   function automatic bit exp_busy(int m, logic [4:0] a);
      if (!in_range(m, a)) return 1'b0;
      if (m_byp[m] && wr_en && wr_addr == a) return alloc_en && (alloc_addr == a);
      return m_busy[m][a];
   endfunction

   task automatic check_outputs();
      bit          st;
      logic [31:0] bv;
      st = 0;
      for (int k = 0; k < 2; k++) begin
         check($sformatf("a_rd_data%0d", k), 64'(rd_data_a[k*32 +: 32]), 64'(exp_data(0, rd_addr_a[k*5 +: 5])));
         check($sformatf("a_rd_busy%0d", k), 64'(rd_busy_a[k]), 64'(exp_busy(0, rd_addr_a[k*5 +: 5])));
         st |= exp_busy(0, rd_addr_a[k*5 +: 5]) & rd_used_a[k];
      end
      check("a_stall", 64'(stall_a), 64'(st));
      bv = '0;
      for (int r = 0; r < 32; r++) bv[r] = m_busy[0][r];
      check("a_busy_vec", 64'(busy_vec_a), 64'(bv));

      st = 0;
      for (int k = 0; k < 3; k++) begin
         check($sformatf("b_rd_data%0d", k), 64'(rd_data_b[k*32 +: 32]), 64'(exp_data(1, rd_addr_b[k*5 +: 5])));
         check($sformatf("b_rd_busy%0d", k), 64'(rd_busy_b[k]), 64'(exp_busy(1, rd_addr_b[k*5 +: 5])));
         st |= exp_busy(1, rd_addr_b[k*5 +: 5]) & rd_used_b[k];
      end
      check("b_stall", 64'(stall_b), 64'(st));
      bv = '0;
      for (int r = 0; r < 16; r++) bv[r] = m_busy[1][r];
      check("b_busy_vec", 64'(busy_vec_b), 64'(bv));
   endtask

   // Architectural effect of one clock edge, from the scoreboard rules.
   task automatic model_clock();
      for (int m = 0; m < 2; m++) begin
         if (reset) begin
            for (int r = 0; r < 32; r++) begin
               m_regs[m][r] = '0;
               m_busy[m][r] = 1'b0;
            end
         end else begin
            for (int r = 1; r < m_nregs[m]; r++) begin
               if (alloc_en && int'(alloc_addr) == r)   m_busy[m][r] = 1'b1;
               else if (flush)                          m_busy[m][r] = 1'b0;
               else if (wr_en && int'(wr_addr) == r)    m_busy[m][r] = 1'b0;
            end
            if (wr_en && in_range(m, wr_addr)) m_regs[m][wr_addr] = wr_data;
         end
      end
   endtask

   task automatic step();
      #2;
      check_outputs();
      @(posedge clk);
      model_clock();
      @(negedge clk);
   endtask

   task automatic idle();
      reset = 0; wr_en = 0; alloc_en = 0; flush = 0;
      wr_addr = 0; alloc_addr = 0; wr_data = 0;
   endtask

   task automatic rd(input logic [4:0] a0, input logic [4:0] a1, input logic [1:0] used);
      rd_addr_a = {a1, a0};
      rd_used_a = used;
      rd_addr_b = {5'd20, a1, a0};
      rd_used_b = {1'b1, used};
   endtask

   initial begin
      idle();
      reset = 1;
      rd(5'd5, 5'd0, 2'b11);
      @(posedge clk);
      model_clock();
      @(negedge clk);
      reset = 0;

      // Post-reset reads of x5/x0 (and address 20 on instance b)
      rd(5'd5, 5'd0, 2'b11); step();

      // Write x5 while reading it: a forwards, b shows old value until next cycle
      wr_en = 1; wr_addr = 5; wr_data = 32'hDEADBEEF; step();
      idle(); step();

      // Writes and allocs to x0 are ignored
      wr_en = 1; wr_addr = 0; wr_data = 32'hFFFFFFFF; alloc_en = 1; alloc_addr = 0;
      rd(5'd0, 5'd5, 2'b11); step();
      idle(); step();

      // Alloc x7, consume it, then writeback with forwarding
      alloc_en = 1; alloc_addr = 7; step();
      idle(); rd(5'd7, 5'd5, 2'b01); step();
      rd(5'd7, 5'd5, 2'b00); step();
      rd(5'd7, 5'd5, 2'b01); wr_en = 1; wr_addr = 7; wr_data = 32'h1234; step();
      idle(); step();

      // Flush with concurrent alloc leaves only the new producer busy
      alloc_en = 1; alloc_addr = 3; rd(5'd3, 5'd9, 2'b11); step();
      alloc_addr = 9; step();
      alloc_addr = 4; flush = 1; rd(5'd3, 5'd4, 2'b11); step();
      idle(); step();

      // Alloc and write the same register: data lands, busy stays set
      alloc_en = 1; alloc_addr = 3; wr_en = 1; wr_addr = 3; wr_data = 32'h55;
      rd(5'd3, 5'd4, 2'b11); step();
      idle(); step();

      // Reset discards a same-cycle alloc and write
      reset = 1; alloc_en = 1; alloc_addr = 10; wr_en = 1; wr_addr = 10; wr_data = 32'hAA;
      rd(5'd10, 5'd3, 2'b11); step();
      idle(); step();

      // Randomized traffic, reads biased toward recently touched registers
      for (int i = 0; i < 1500; i++) begin
         logic [4:0] hot;
         hot        = 5'($urandom_range(0, 7));
         reset      = ($urandom_range(0, 99) == 0);
         wr_en      = $urandom_range(0, 1);
         wr_addr    = ($urandom_range(0, 1) != 0) ? hot : 5'($urandom);
         wr_data    = $urandom;
         alloc_en   = $urandom_range(0, 1);
         alloc_addr = ($urandom_range(0, 1) != 0) ? hot : 5'($urandom);
         flush      = ($urandom_range(0, 15) == 0);
         rd_addr_a  = {(($urandom_range(0, 1) != 0) ? wr_addr : 5'($urandom_range(0, 7))), 5'($urandom)};
         rd_used_a  = 2'($urandom);
         rd_addr_b  = {5'($urandom), (($urandom_range(0, 1) != 0) ? wr_addr : hot), 5'($urandom_range(0, 7))};
         rd_used_b  = 3'($urandom);
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
